sync_debounce: RTL
==================

Name: sync_debounce

Overview:
Multi-bit clock-domain-crossing input conditioner. Each channel has a configurable-depth flop synchronizer, a stable-count debounce/glitch filter and registered edge-detect pulses. Used for asynchronous external inputs (buttons, status pins, slow flags from other clock domains) before they reach control logic in the clk domain. Channels are independent; no multi-bit coherency is provided.

Parameters:
WIDTH, 1, number of independent channels
STAGES, 2, synchronizer flop depth per channel; must be >= 2
FILTER_CYCLES, 4, consecutive synchronized cycles a new level must persist before out follows it; must be >= 1 (1 = no filtering, registered output only)
RESET_VAL, {WIDTH{1'b0}}, reset value of synchronizer flops and out

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
in  in  WIDTH  asynchronous inputs
out  out  WIDTH  synchronized, debounced level
rise  out  WIDTH  one-cycle pulse per channel when out goes 0->1
fall  out  WIDTH  one-cycle pulse per channel when out goes 1->0
changed  out  1  OR-reduction of (rise | fall), registered together with them

Behaviour:
- Reset (async assert, synchronous release by clk): sync flops and out = RESET_VAL; counters = 0; rise = fall = 0; changed = 0.
- Synchronizer: STAGES-deep chain per bit, all flops ASYNC_REG = "TRUE"; s = last stage.
- Filter per channel, counter cnt with width clog2(FILTER_CYCLES) (min 1):
  - s == out: cnt <= 0.
  - s != out and cnt == FILTER_CYCLES-1: out <= s, cnt <= 0, and the matching rise/fall <= 1.
  - s != out otherwise: cnt <= cnt+1.
- rise/fall/changed are registered; they are high for exactly the first cycle out shows the new value, otherwise 0.
- Latency: level sampled at edge N appears on out after edge N+STAGES+FILTER_CYCLES-1, i.e. STAGES+FILTER_CYCLES edges counting the sampling edge.
- Glitch rejection: any level lasting fewer than FILTER_CYCLES cycles at s leaves out unchanged. cnt clears on the first cycle s == out again, with no partial credit carried over.
- FILTER_CYCLES = 1: out follows s every cycle; a toggle every cycle yields alternating rise/fall every cycle.
- Simultaneous channel events are independent: rise and fall may both be non-zero in the same cycle on different bits, and changed = 1.
- Reset mid-filter: pending count is discarded and no pulse is produced. After release, a held input that differs from RESET_VAL propagates with full latency and produces a normal pulse.
- Counter never exceeds FILTER_CYCLES-1; no wrap-around.
- Elaboration check: STAGES < 2 or FILTER_CYCLES < 1 is a fatal error.

Decomposition:
- Shared package: clog2 helper function and the derived counter-width constant CNT_W.
- One natural sub-module, sync_debounce_ch: a single-bit channel containing the chain, cnt, out bit and rise/fall bits. It is instantiated WIDTH times in a generate loop.
- The top level holds only the generate loop and the changed register.

Test Plan:
All scenarios use WIDTH=4, STAGES=2, FILTER_CYCLES=4 unless stated.
1. rst=1 with in=4'hF, then rst=0 -> out=4'h0, rise=fall=0, changed=0 while in reset. out=4'hF exactly 6 edges after the first post-release edge, with rise=4'hF and changed=1 for one cycle.
2. in[0] 0->1 held -> out[0]=1 exactly 6 edges after the sampling edge; rise[0]=1 and changed=1 for exactly one cycle; fall=0 throughout.
3. in[1]=1 for 3 cycles then 0 -> out[1] stays 0, rise/fall stay 0. The same input held for 4 cycles -> out[1] goes 1.
4. in 4'h0->4'hA held, then 4'hA->4'h5 held -> out=4'hA with rise=4'hA, then out=4'h5 in one cycle with rise=4'h5, fall=4'hA, changed=1.
5. in[2] held 1, rst pulsed 3 cycles after the change (mid-count) -> out=0, no pulse. After release, out[2]=1 after 6 edges with a single rise[2] pulse.
6. STAGES=3, FILTER_CYCLES=1 instance, in[3] toggling every cycle -> out[3] reproduces the toggle delayed by 4 edges; rise[3] and fall[3] alternate every cycle.

Source files
------------

// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared helpers for the debounce counter width and parameter validation
package sync_debounce_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int filter_cycles);
    return clog2(filter_cycles) < 1 ? 1 : clog2(filter_cycles);
  endfunction
  function automatic bit params_ok(input int stages, input int filter_cycles);
    return stages >= 2 && filter_cycles >= 1;
  endfunction
endpackage

// File: rtl/sync_debounce_ch.sv
// sync_debounce_ch: one channel of synchronizer chain, stable-count filter and edge pulses
module sync_debounce_ch
  import sync_debounce_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic evt
);
  localparam int CNT_W = cnt_w(FILTER_CYCLES);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic s;
  assign s = sync[STAGES-1];
  // evt marks the edge on which out takes the new level; the top registers changed from it
  assign evt = (s != out) && (cnt == CNT_W'(FILTER_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {STAGES{RESET_VAL}};
    else     sync <= {sync[STAGES-2:0], in};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= evt & s;
      fall <= evt & ~s;
      if (s == out || evt) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
      if (evt) out <= s;
    end
  end
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: multi-bit CDC input conditioner with per-channel debounce and edge pulses
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  logic [WIDTH-1:0] evt;
  if (!params_ok(STAGES, FILTER_CYCLES)) begin : g_bad_params
    $fatal(1, "sync_debounce: STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_ch #(
      .STAGES(STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL(RESET_VAL[i])
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .in(in[i]),
      .out(out[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .evt(evt[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed <= 1'b0;
    else     changed <= |evt;
  end
endmodule
